capture_ctrl: RTL and testbench
===============================

Name: capture_ctrl

Overview:
- Sequences one acquisition of the 8-bit channel sample stream into the circular capture RAM.
- Generates the decimated write strobe and the RAM write address, and holds off the trigger until enough pre-trigger history is stored.
- After a trigger, counts the programmed number of post-trigger samples, then freezes the RAM and flags completion.
- Sits between the command processor (run/clear/config), the trigger logic (triggered) and the sample RAM (write port).

Parameters:
ENTRIES, 384, capture RAM depth in samples
AW, 9, address width; 2^AW >= ENTRIES

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
run  input  1  one-cycle start pulse from command processor
clr_cap_done  input  1  one-cycle pulse; releases a finished capture
decimator  input  4  sample every 2^decimator clk cycles
trig_posn  input  AW  samples kept after the trigger
triggered  input  1  trigger event from trigger logic
wrt_smpl  output  1  RAM write strobe for the current smpl
waddr  output  AW  RAM write address, valid while wrt_smpl=1
armed  output  1  trigger is accepted in this state
capture_done  output  1  capture complete, RAM frozen
trig_addr  output  AW  address of the first sample at/after the trigger

Behaviour:
- Reset: rst is sampled on clk posedge only.
  - State=IDLE; waddr, trig_addr, pre_cnt, post_cnt and dec_cnt=0.
  - wrt_smpl=0, armed=0, capture_done=0.
  - rst asserted in any state, including mid-capture, aborts the capture with no partial done.
- Configuration:
  - trig_posn is used as min(trig_posn, ENTRIES-1).
  - pre_need = ENTRIES - trig_posn_eff, always >= 1.
  - decimator and trig_posn are latched on the run pulse and held constant for the whole capture.
- Decimation: a 16-bit dec_cnt is cleared on entering FILL.
  - In FILL/ARMED/POST, dec_cnt increments every cycle and wraps to 0 at term = 2^decimator - 1.
  - wrt_smpl = (state in {FILL, ARMED, POST}) && dec_cnt == term. It is a decode of registers; no extra latency.
  - With decimator=0, wrt_smpl is high every cycle in capture states.
- Address: waddr is cleared on run.
  - On every cycle with wrt_smpl=1, waddr increments, wrapping from ENTRIES-1 to 0.
- State machine (IDLE, FILL, ARMED, POST, DONE):
  - IDLE: run=1 -> FILL, next cycle. Latch config, clear counters and waddr.
  - FILL: pre_cnt counts wrt_smpl strobes. On the strobe that makes pre_cnt == pre_need -> ARMED. triggered is ignored.
  - ARMED: armed=1, writes continue. On triggered=1:
    - trig_addr <= waddr. If wrt_smpl is also high that cycle, that sample is the trigger sample and is not counted as post.
    - Next state is POST, or DONE directly if trig_posn_eff==0.
  - POST: post_cnt counts strobes. On the strobe that makes post_cnt == trig_posn_eff -> DONE. triggered is ignored.
  - DONE: capture_done=1, wrt_smpl=0, waddr holds.
    - clr_cap_done=1 -> IDLE, capture_done=0 next cycle.
    - trig_addr holds until the next run.
- run is ignored in every state except IDLE.
- clr_cap_done outside DONE is ignored.
- armed is registered, high exactly while state=ARMED.

Test Plan:
- Reset: rst high for 2 cycles with run=1 -> all outputs 0, state stays IDLE, no wrt_smpl.
- Baseline (decimator=0, trig_posn=100, run pulse):
  - wrt_smpl is high every cycle; waddr runs 0..283.
  - armed rises after the 284th write.
  - triggered pulse while waddr=300 -> trig_addr=300, then exactly 100 more writes, last at waddr=16 after wrap.
  - capture_done=1 with waddr held at 17.
- Decimation (decimator=3, trig_posn=383): wrt_smpl occurs once every 8 cycles; armed after 1 write (8 cycles); trigger -> 383 post writes over 3064 cycles, then done.
- Zero post (trig_posn=0, decimator=0): armed after 384 writes; triggered -> capture_done next cycle, no further wrt_smpl, trig_addr = waddr at trigger.
- Ignored events:
  - triggered during FILL and during POST -> no change to trig_addr or post count.
  - run during ARMED -> no restart.
  - clr_cap_done in DONE -> IDLE; a second run restarts with waddr=0.
- Mid-capture reset: rst asserted in POST after 50 of 100 post writes -> next cycle IDLE, capture_done never asserts, all outputs 0.

Source files
------------

// File: rtl/capture_ctrl.sv
// capture_ctrl: sequences one decimated acquisition into the circular capture RAM
module capture_ctrl #(
  parameter int ENTRIES = 384,
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic          clr_cap_done,
  input  logic [3:0]    decimator,
  input  logic [AW-1:0] trig_posn,
  input  logic          triggered,
  output logic          wrt_smpl,
  output logic [AW-1:0] waddr,
  output logic          armed,
  output logic          capture_done,
  output logic [AW-1:0] trig_addr
);
  typedef enum logic [2:0] {IDLE, FILL, ARMED, POST, DONE} state_t;
  localparam logic [AW-1:0] LAST = AW'(ENTRIES - 1);
  localparam logic [AW:0] DEPTH = (AW+1)'(ENTRIES);
  state_t state;
  logic [3:0] dec;
  logic [AW-1:0] tp_eff, post_cnt;
  logic [AW:0] pre_cnt, pre_need;
  logic [15:0] dec_cnt, term;
  logic cap;
  assign term = (16'd1 << dec) - 16'd1;
  assign pre_need = DEPTH - {1'b0, tp_eff};
  assign cap = state inside {FILL, ARMED, POST};
  assign wrt_smpl = cap && dec_cnt == term;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      dec <= '0;
      tp_eff <= '0;
      dec_cnt <= '0;
      waddr <= '0;
      trig_addr <= '0;
      pre_cnt <= '0;
      post_cnt <= '0;
      armed <= 1'b0;
      capture_done <= 1'b0;
    end else begin
      if (cap) dec_cnt <= (dec_cnt == term) ? '0 : dec_cnt + 16'd1;
      if (wrt_smpl) waddr <= (waddr == LAST) ? '0 : waddr + 1'b1;
      case (state)
        IDLE: if (run) begin
          state <= FILL;
          dec <= decimator;
          tp_eff <= (trig_posn > LAST) ? LAST : trig_posn;
          dec_cnt <= '0;
          waddr <= '0;
          trig_addr <= '0;
          pre_cnt <= '0;
          post_cnt <= '0;
        end
        FILL: if (wrt_smpl) begin
          pre_cnt <= pre_cnt + 1'b1;
          if (pre_cnt + 1'b1 == pre_need) begin
            state <= ARMED;
            armed <= 1'b1;
          end
        end
        // a sample written in the trigger cycle is the trigger sample, not a post sample
        ARMED: if (triggered) begin
          trig_addr <= waddr;
          armed <= 1'b0;
          state <= (tp_eff == '0) ? DONE : POST;
          capture_done <= tp_eff == '0;
        end
        POST: if (wrt_smpl) begin
          post_cnt <= post_cnt + 1'b1;
          if (post_cnt + 1'b1 == tp_eff) begin
            state <= DONE;
            capture_done <= 1'b1;
          end
        end
        DONE: if (clr_cap_done) begin
          state <= IDLE;
          capture_done <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_capture_ctrl.sv
// tb_capture_ctrl: directed + randomized capture runs checked against a count-based model
module tb_capture_ctrl;
  localparam int ENTRIES = 384;
  localparam int AW = 9;
  logic clk = 0, rst = 1, run = 0, clr_cap_done = 0, triggered = 0;
  logic [3:0] decimator = 0;
  logic [AW-1:0] trig_posn = 0;
  logic wrt_smpl, armed, capture_done;
  logic [AW-1:0] waddr, trig_addr;
  int n_chk = 0, n_fail = 0;
  bit check_en = 0;
  int m_phase = 0, m_k = 0, m_writes = 0, m_base = 0, m_dec = 0, m_tp = 0, m_taddr = 0;
  always #5 clk = ~clk;
  capture_ctrl #(.ENTRIES(ENTRIES), .AW(AW)) dut (
    .clk(clk), .rst(rst), .run(run), .clr_cap_done(clr_cap_done),
    .decimator(decimator), .trig_posn(trig_posn), .triggered(triggered),
    .wrt_smpl(wrt_smpl), .waddr(waddr), .armed(armed),
    .capture_done(capture_done), .trig_addr(trig_addr)
  );
  // phases: 0 idle, 1 fill, 2 armed, 3 post, 4 done; m_k = cycles since capture start
  function automatic bit m_wrt();
    return (m_phase inside {1, 2, 3}) && (m_k % (1 << m_dec)) == (1 << m_dec) - 1;
  endfunction
  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic wait_phase(int p, int budget);
    int n = 0;
    while (m_phase != p && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (m_phase != p) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_phase: timeout waiting for phase %0d", p);
    end
  endtask
  always @(posedge clk) begin
    bit w;
    w = m_wrt();
    if (rst) begin
      m_phase = 0; m_k = 0; m_writes = 0; m_base = 0; m_dec = 0; m_tp = 0; m_taddr = 0;
    end else if (m_phase == 0) begin
      if (run) begin
        m_phase = 1; m_k = 0; m_writes = 0; m_taddr = 0;
        m_dec = int'(decimator);
        m_tp = (int'(trig_posn) > ENTRIES - 1) ? ENTRIES - 1 : int'(trig_posn);
      end
    end else if (m_phase == 4) begin
      if (clr_cap_done) m_phase = 0;
    end else begin
      m_k++;
      if (m_phase == 2 && triggered) begin
        m_taddr = m_writes % ENTRIES;
        m_base = m_writes + (w ? 1 : 0);
        m_phase = (m_tp == 0) ? 4 : 3;
      end
      if (w) m_writes++;
      if (m_phase == 1 && w && m_writes == ENTRIES - m_tp) m_phase = 2;
      else if (m_phase == 3 && w && m_writes - m_base == m_tp) m_phase = 4;
    end
  end
  always @(negedge clk) if (check_en) begin
    chk("wrt_smpl", int'(wrt_smpl), int'(m_wrt()));
    chk("waddr", int'(waddr), m_writes % ENTRIES);
    chk("armed", int'(armed), int'(m_phase == 2));
    chk("capture_done", int'(capture_done), int'(m_phase == 4));
    chk("trig_addr", int'(trig_addr), m_taddr);
  end
  task automatic pulse_run();
    run = 1; @(negedge clk); run = 0;
  endtask
  task automatic pulse_clr();
    clr_cap_done = 1; @(negedge clk); clr_cap_done = 0;
  endtask
  initial begin
    int n;
    rst = 1; run = 1;
    repeat (2) @(negedge clk);
    check_en = 1;
    chk("rst_waddr", int'(waddr), 0);
    chk("rst_wrt", int'(wrt_smpl), 0);
    chk("rst_armed", int'(armed), 0);
    chk("rst_done", int'(capture_done), 0);
    chk("rst_trig_addr", int'(trig_addr), 0);
    rst = 0; run = 0;
    @(negedge clk);
    chk("idle_no_wrt", int'(wrt_smpl), 0);
    // baseline with ignored events sprinkled in
    decimator = 0; trig_posn = 100;
    pulse_run();
    decimator = 5; trig_posn = 7;
    repeat (10) @(negedge clk);
    triggered = 1; @(negedge clk); triggered = 0;
    wait_phase(2, 1000);
    chk("base_armed_waddr", int'(waddr), 284);
    chk("base_armed", int'(armed), 1);
    pulse_run();
    n = 0;
    while (m_writes != 300 && n < 100) begin @(negedge clk); n++; end
    triggered = 1; @(negedge clk); triggered = 0;
    repeat (20) @(negedge clk);
    triggered = 1; @(negedge clk); triggered = 0;
    wait_phase(4, 500);
    chk("base_trig_addr", int'(trig_addr), 300);
    chk("base_done_waddr", int'(waddr), 17);
    chk("base_done", int'(capture_done), 1);
    repeat (5) @(negedge clk);
    chk("base_hold_waddr", int'(waddr), 17);
    pulse_clr();
    chk("clr_done", int'(capture_done), 0);
    // restart, then abort with reset midway through post
    decimator = 0; trig_posn = 100;
    pulse_run();
    chk("restart_waddr", int'(waddr), 0);
    wait_phase(2, 1000);
    triggered = 1; @(negedge clk); triggered = 0;
    n = 0;
    while (m_writes - m_base != 50 && n < 200) begin @(negedge clk); n++; end
    rst = 1; @(negedge clk); rst = 0;
    chk("abort_waddr", int'(waddr), 0);
    chk("abort_wrt", int'(wrt_smpl), 0);
    chk("abort_armed", int'(armed), 0);
    chk("abort_done", int'(capture_done), 0);
    repeat (120) @(negedge clk);
    chk("abort_never_done", int'(capture_done), 0);
    // decimation by 8, maximum post count
    decimator = 3; trig_posn = 383;
    run = 1; @(negedge clk); run = 0;
    n = 1;
    while (!armed && n < 100) begin @(negedge clk); n++; end
    chk("dec_armed_cycles", n, 9);
    chk("dec_armed_waddr", int'(waddr), 1);
    triggered = 1; @(negedge clk); triggered = 0;
    n = 1;
    while (!capture_done && n < 5000) begin @(negedge clk); n++; end
    chk("dec_post_cycles", n, 3064);
    chk("dec_trig_addr", int'(trig_addr), 1);
    chk("dec_done_waddr", int'(waddr), 0);
    pulse_clr();
    // zero post-trigger samples
    decimator = 0; trig_posn = 0;
    pulse_run();
    wait_phase(2, 1000);
    chk("zero_armed_waddr", int'(waddr), 0);
    repeat (5) @(negedge clk);
    triggered = 1; @(negedge clk); triggered = 0;
    chk("zero_done", int'(capture_done), 1);
    chk("zero_trig_addr", int'(trig_addr), 5);
    chk("zero_waddr", int'(waddr), 6);
    chk("zero_no_wrt", int'(wrt_smpl), 0);
    pulse_clr();
    // randomized captures with noise on triggered/run/clr_cap_done
    for (int c = 0; c < 6; c++) begin
      decimator = 4'($urandom_range(0, 2));
      trig_posn = AW'($urandom_range(0, 511));
      pulse_run();
      n = 0;
      while (m_phase != 4 && n < 20000) begin
        triggered = ($urandom_range(0, 15) == 0);
        run = ($urandom_range(0, 31) == 0);
        clr_cap_done = ($urandom_range(0, 31) == 0);
        @(negedge clk);
        n++;
      end
      triggered = 0; run = 0; clr_cap_done = 0;
      chk("rand_done", int'(capture_done), 1);
      pulse_clr();
      @(negedge clk);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
